// File: rtl/fetch_queue.sv
// fetch_queue: sequential instruction fetch with a credit-limited request
// stream, an in-flight PC tag FIFO and a DEPTH-entry {inst, pc} queue feeding
// the decode stage over valid/ready. A redirect flushes the queue, marks every
// outstanding request for discard and restarts fetch at the target address.
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0]   CREDIT_LIMIT = (CW + 1)'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE      = CW'(1);

    // Fetch address and credit bookkeeping
    logic [31:0]   fetch_pc_reg, fetch_pc_next;
    logic [CW-1:0] inflight_reg, inflight_next;
    logic [CW-1:0] drop_reg, drop_next;
    logic          err_reg, err_next;

    // PC tags of requests still waiting for their response
    logic [31:0]   tag_mem [DEPTH];
    logic [PW-1:0] tag_wr_ptr_reg, tag_wr_ptr_next;
    logic [PW-1:0] tag_rd_ptr_reg, tag_rd_ptr_next;
    logic [31:0]   resp_tag;

    // Returned instructions waiting for the consumer
    logic [31:0]   inst_mem [DEPTH];
    logic [31:0]   pc_mem   [DEPTH];
    logic [PW-1:0] data_wr_ptr_reg, data_wr_ptr_next;
    logic [PW-1:0] data_rd_ptr_reg, data_rd_ptr_next;
    logic [CW-1:0] count_reg, count_next;
    logic [CW-1:0] count_after_pop;

    // Registered copy of the queue head
    logic [31:0]   inst_reg, inst_next;
    logic [31:0]   inst_pc_reg, inst_pc_next;

    // Handshake decodes
    logic [CW:0]   credit_sum;
    logic          req_fire;
    logic          resp_known;
    logic          resp_spurious;
    logic          resp_drop;
    logic          push;
    logic          pop;

    // Requests are allowed only while queue slots plus outstanding requests
    // leave room, so every response is guaranteed a free slot on arrival.
    assign credit_sum     = {1'b0, count_reg} + {1'b0, inflight_reg};
    assign imem_req_valid = !rst && (credit_sum < CREDIT_LIMIT);
    assign imem_req_addr  = fetch_pc_reg;

    assign req_fire      = imem_req_valid && imem_req_ready;
    assign resp_known    = imem_resp_valid && (inflight_reg != '0);
    assign resp_spurious = imem_resp_valid && (inflight_reg == '0);
    assign resp_drop     = resp_known && (drop_reg != '0);
    // A redirect empties the queue, so nothing enters or leaves it that cycle
    assign push          = resp_known && !resp_drop && !redirect_valid;
    assign pop           = (count_reg != '0) && inst_ready && !redirect_valid;
    assign resp_tag      = tag_mem[tag_rd_ptr_reg];

    assign inst_valid = (count_reg != '0);
    assign inst       = inst_reg;
    assign inst_pc    = inst_pc_reg;
    assign err        = err_reg;

    // Next-state computation for counters, pointers, fetch PC and queue head
    always_comb begin
        fetch_pc_next    = fetch_pc_reg;
        inflight_next    = inflight_reg + CW'(req_fire) - CW'(resp_known);
        drop_next        = drop_reg;
        err_next         = err_reg || resp_spurious;
        tag_wr_ptr_next  = tag_wr_ptr_reg + PW'(req_fire);
        tag_rd_ptr_next  = tag_rd_ptr_reg + PW'(resp_known);
        data_wr_ptr_next = data_wr_ptr_reg + PW'(push);
        data_rd_ptr_next = data_rd_ptr_reg + PW'(pop);
        count_after_pop  = count_reg - CW'(pop);
        count_next       = count_after_pop + CW'(push);
        inst_next        = inst_reg;
        inst_pc_next     = inst_pc_reg;

        if (req_fire) begin
            fetch_pc_next = fetch_pc_reg + 32'd4;
        end

        if (resp_drop) begin
            drop_next = drop_reg - CNT_ONE;
        end

        // Head refresh: an arrival into an otherwise empty queue bypasses
        // storage; after a pop the following stored entry becomes the head.
        if (push && (count_after_pop == '0)) begin
            inst_next    = imem_resp_data;
            inst_pc_next = resp_tag;
        end else if (pop && (count_after_pop != '0)) begin
            inst_next    = inst_mem[data_rd_ptr_next];
            inst_pc_next = pc_mem[data_rd_ptr_next];
        end

        // Redirect overrides: every request still outstanding after this
        // cycle's handshakes (including one accepted now) is discarded.
        if (redirect_valid) begin
            fetch_pc_next    = redirect_pc & ~32'h3;
            drop_next        = inflight_next;
            data_wr_ptr_next = '0;
            data_rd_ptr_next = '0;
            count_next       = '0;
        end
    end

    // State registers, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_reg    <= RESET_PC;
            inflight_reg    <= '0;
            drop_reg        <= '0;
            err_reg         <= 1'b0;
            tag_wr_ptr_reg  <= '0;
            tag_rd_ptr_reg  <= '0;
            data_wr_ptr_reg <= '0;
            data_rd_ptr_reg <= '0;
            count_reg       <= '0;
            inst_reg        <= '0;
            inst_pc_reg     <= '0;
        end else begin
            fetch_pc_reg    <= fetch_pc_next;
            inflight_reg    <= inflight_next;
            drop_reg        <= drop_next;
            err_reg         <= err_next;
            tag_wr_ptr_reg  <= tag_wr_ptr_next;
            tag_rd_ptr_reg  <= tag_rd_ptr_next;
            data_wr_ptr_reg <= data_wr_ptr_next;
            data_rd_ptr_reg <= data_rd_ptr_next;
            count_reg       <= count_next;
            inst_reg        <= inst_next;
            inst_pc_reg     <= inst_pc_next;
        end
    end

    // Record the address of each accepted request for tagging its response
    always_ff @(posedge clk) begin
        if (req_fire) begin
            tag_mem[tag_wr_ptr_reg] <= fetch_pc_reg;
        end
    end

    // Store returned instructions with their PCs
    always_ff @(posedge clk) begin
        if (push) begin
            inst_mem[data_wr_ptr_reg] <= imem_resp_data;
            pc_mem[data_wr_ptr_reg]   <= resp_tag;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed checks of fetch_queue with a latency-programmable
// instruction memory model. Memory returns (addr ^ 32'h5A5A_0000) as data.
module tb_fetch_queue;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        err;

    // Second instance: non-zero reset PC, memory always ready, never responds
    logic        w_req_valid;
    logic [31:0] w_req_addr;
    logic        w_inst_valid;
    logic [31:0] w_inst;
    logic [31:0] w_inst_pc;
    logic        w_err;

    int n_cmp;
    int n_bad;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mem_req_t;

    mem_req_t pending[$];
    int       mem_lat;
    int       req_count;
    logic     spur_req;
    int       mem_cycle;

    fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) u_dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst            (inst),
        .inst_pc         (inst_pc),
        .err             (err)
    );

    fetch_queue #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) u_dut_wrap (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (w_req_valid),
        .imem_req_ready  (1'b1),
        .imem_req_addr   (w_req_addr),
        .imem_resp_valid (1'b0),
        .imem_resp_data  (32'h0),
        .redirect_valid  (1'b0),
        .redirect_pc     (32'h0),
        .inst_valid      (w_inst_valid),
        .inst_ready      (1'b0),
        .inst            (w_inst),
        .inst_pc         (w_inst_pc),
        .err             (w_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %-18s got %08h expected %08h", tag, got, exp);
        end else begin
            $display("ok   %-18s %08h", tag, got);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Memory model: decides each cycle's response and request acceptance
    // shortly after the falling edge, once the test has driven its inputs.
    initial begin
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;
        mem_cycle       = 0;
        forever begin
            @(negedge clk);
            #1;
            mem_cycle++;
            imem_resp_valid = 1'b0;
            imem_resp_data  = 32'h0;
            if (rst) begin
                pending.delete();
            end else begin
                if (spur_req) begin
                    imem_resp_valid = 1'b1;
                    imem_resp_data  = 32'hBAD0_BAD0;
                    spur_req        = 1'b0;
                end else if (pending.size() > 0 && pending[0].due <= mem_cycle) begin
                    imem_resp_valid = 1'b1;
                    imem_resp_data  = pending[0].addr ^ 32'h5A5A_0000;
                    void'(pending.pop_front());
                end
                if (imem_req_valid && imem_req_ready) begin
                    pending.push_back('{addr: imem_req_addr, due: mem_cycle + mem_lat});
                    req_count++;
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        n_cmp          = 0;
        n_bad          = 0;
        rst            = 1'b1;
        imem_req_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        inst_ready     = 1'b0;
        mem_lat        = 1;
        spur_req       = 1'b0;
        req_count      = 0;

        // Reset values
        repeat (2) @(negedge clk);
        check_eq("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check_eq("rst_req_addr", imem_req_addr, 32'h0);
        check_eq("rst_inst_valid", 32'(inst_valid), 32'd0);
        check_eq("rst_inst", inst, 32'h0);
        check_eq("rst_inst_pc", inst_pc, 32'h0);
        check_eq("rst_err", 32'(err), 32'd0);
        check_eq("rst_wrap_addr", w_req_addr, 32'hFFFF_FFF8);
        check_eq("rst_wrap_valid", 32'(w_req_valid), 32'd0);

        // Streaming with 1-cycle memory, consumer always ready; wrap instance
        // walks FFFF_FFF8, FFFF_FFFC, 0, 4 then runs out of credit.
        imem_req_ready = 1'b1;
        inst_ready     = 1'b1;
        mem_lat        = 1;
        rst            = 1'b0;
        #1;
        check_eq("s1_req_valid", 32'(imem_req_valid), 32'd1);
        check_eq("s1_req_addr0", imem_req_addr, 32'h0);
        check_eq("wrap_valid0", 32'(w_req_valid), 32'd1);
        check_eq("wrap_addr0", w_req_addr, 32'hFFFF_FFF8);
        @(negedge clk);
        check_eq("s1_first_empty", 32'(inst_valid), 32'd0);
        check_eq("wrap_addr1", w_req_addr, 32'hFFFF_FFFC);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check_eq("s1_inst_valid", 32'(inst_valid), 32'd1);
            check_eq("s1_inst_pc", inst_pc, 32'(4 * i));
            check_eq("s1_inst", inst, 32'h5A5A_0000 ^ 32'(4 * i));
            if (i == 0) check_eq("wrap_addr2", w_req_addr, 32'h0000_0000);
            if (i == 1) check_eq("wrap_addr3", w_req_addr, 32'h0000_0004);
            if (i == 2) check_eq("wrap_no_credit", 32'(w_req_valid), 32'd0);
        end
        check_eq("s1_err", 32'(err), 32'd0);
        // Asynchronous reset mid-stream, well before the next rising edge
        #3;
        rst = 1'b1;
        #1;
        check_eq("async_inst_valid", 32'(inst_valid), 32'd0);
        check_eq("async_req_valid", 32'(imem_req_valid), 32'd0);

        // Consumer stalled: queue fills after exactly four requests
        imem_req_ready = 1'b1;
        inst_ready     = 1'b0;
        mem_lat        = 1;
        req_count      = 0;
        do_reset();
        repeat (8) @(negedge clk);
        check_eq("s2_req_count", 32'(req_count), 32'd4);
        check_eq("s2_req_valid", 32'(imem_req_valid), 32'd0);
        check_eq("s2_head_valid", 32'(inst_valid), 32'd1);
        check_eq("s2_head_pc", inst_pc, 32'h0);
        check_eq("s2_head_inst", inst, 32'h5A5A_0000);
        inst_ready = 1'b1;
        @(negedge clk);
        check_eq("s2_pc_a", inst_pc, 32'h4);
        check_eq("s2_resume_valid", 32'(imem_req_valid), 32'd1);
        check_eq("s2_resume_addr", imem_req_addr, 32'h10);
        @(negedge clk);
        check_eq("s2_pc_b", inst_pc, 32'h8);
        @(negedge clk);
        check_eq("s2_pc_c", inst_pc, 32'hC);
        @(negedge clk);
        check_eq("s2_pc_d", inst_pc, 32'h10);
        check_eq("s2_inst_d", inst, 32'h5A5A_0010);

        // Latency 3, two requests outstanding, redirect to 0x103
        imem_req_ready = 1'b1;
        inst_ready     = 1'b1;
        mem_lat        = 3;
        do_reset();
        repeat (2) @(negedge clk);
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h103;
        @(negedge clk);
        redirect_valid = 1'b0;
        imem_req_ready = 1'b1;
        check_eq("s3_req_addr", imem_req_addr, 32'h100);
        check_eq("s3_req_valid", 32'(imem_req_valid), 32'd1);
        check_eq("s3_flushed", 32'(inst_valid), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("s3_no_stale", 32'(inst_valid), 32'd0);
        end
        @(negedge clk);
        check_eq("s3_valid", 32'(inst_valid), 32'd1);
        check_eq("s3_pc0", inst_pc, 32'h100);
        check_eq("s3_inst0", inst, 32'h5A5A_0100);
        @(negedge clk);
        check_eq("s3_pc1", inst_pc, 32'h104);

        // Redirect in the same cycle as a request acceptance and a response
        imem_req_ready = 1'b1;
        inst_ready     = 1'b1;
        mem_lat        = 1;
        do_reset();
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        @(negedge clk);
        redirect_valid = 1'b0;
        check_eq("s4_empty_a", 32'(inst_valid), 32'd0);
        check_eq("s4_req_addr", imem_req_addr, 32'h200);
        check_eq("s4_req_valid", 32'(imem_req_valid), 32'd1);
        @(negedge clk);
        check_eq("s4_empty_b", 32'(inst_valid), 32'd0);
        @(negedge clk);
        check_eq("s4_valid", 32'(inst_valid), 32'd1);
        check_eq("s4_pc0", inst_pc, 32'h200);
        check_eq("s4_inst0", inst, 32'h5A5A_0200);
        @(negedge clk);
        check_eq("s4_pc1", inst_pc, 32'h204);

        // Spurious response with nothing in flight
        imem_req_ready = 1'b0;
        inst_ready     = 1'b1;
        mem_lat        = 1;
        do_reset();
        @(negedge clk);
        spur_req = 1'b1;
        @(negedge clk);
        check_eq("s5_err_set", 32'(err), 32'd1);
        check_eq("s5_queue_empty", 32'(inst_valid), 32'd0);
        imem_req_ready = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("s5_valid", 32'(inst_valid), 32'd1);
        check_eq("s5_pc0", inst_pc, 32'h0);
        check_eq("s5_err_sticky", 32'(err), 32'd1);
        do_reset();
        #1;
        check_eq("s5_err_cleared", 32'(err), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
